// File: rtl/d_ff_pipe_pkg.sv
// Shared constants, occupancy-width helper for the d_ff_pipe elastic register pipeline.
package d_ff_pkg;

    localparam int unsigned D_FF_RST_VAL = 0;

    // Bits needed to count 0..depth stages inclusive
    function automatic int unsigned clog2_depth(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/d_ff_pipe_stage.sv
// One elastic pipeline stage: WIDTH-bit register plus valid, pass-through ready.
module d_ff_stage
    import d_ff_pkg::*;
#(
    parameter int unsigned       WIDTH   = 8,
    parameter logic [WIDTH-1:0]  RST_VAL = WIDTH'(D_FF_RST_VAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             up_ready,
    output logic             vld,
    output logic [WIDTH-1:0] data
);

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] data;
    } d_ff_stage_t;

    d_ff_stage_t st;

    // An empty stage always accepts, which is what collapses bubbles
    assign up_ready = !st.vld || dn_ready;
    assign vld      = st.vld;
    assign data     = st.data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st.vld  <= 1'b0;
            st.data <= RST_VAL;
        end else if (flush) begin
            st.vld  <= 1'b0;
            st.data <= RST_VAL;
        end else if (up_ready) begin
            st.vld <= up_valid;
            if (up_valid)
                st.data <= up_data;
        end
    end

endmodule

// File: rtl/d_ff_pipe.sv
// Elastic DEPTH-stage register pipeline with valid/ready on both ends.
// Define D_FF_PIPE_OCC_EN to add the registered occupancy output occ.
module d_ff_pipe
    import d_ff_pkg::*;
#(
    parameter int unsigned       WIDTH   = 8,
    parameter int unsigned       DEPTH   = 4,
    parameter logic [WIDTH-1:0]  RST_VAL = WIDTH'(D_FF_RST_VAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] d_in,
    input  logic             d_valid,
    output logic             d_ready,
    output logic [WIDTH-1:0] q_out,
    output logic             q_valid,
    input  logic             q_ready
`ifdef D_FF_PIPE_OCC_EN
    ,
    output logic [clog2_depth(DEPTH)-1:0] occ
`endif
);

    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] data [DEPTH];

    assign rdy[DEPTH] = q_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_v;
        logic [WIDTH-1:0] up_d;

        if (i == 0) begin : g_head
            assign up_v = d_valid;
            assign up_d = d_in;
        end else begin : g_link
            assign up_v = vld[i-1];
            assign up_d = data[i-1];
        end

        d_ff_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .up_valid (up_v),
            .up_data  (up_d),
            .dn_ready (rdy[i+1]),
            .up_ready (rdy[i]),
            .vld      (vld[i]),
            .data     (data[i])
        );
    end

    assign d_ready = rdy[0] && !flush;
    assign q_out   = data[DEPTH-1];
    assign q_valid = vld[DEPTH-1];

`ifdef D_FF_PIPE_OCC_EN
    localparam int unsigned OCC_W = clog2_depth(DEPTH);

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = d_valid && d_ready;
    assign out_xfer = q_valid && q_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            occ <= '0;
        else if (flush)
            occ <= '0;
        else
            occ <= occ + OCC_W'(in_xfer) - OCC_W'(out_xfer);
    end

    always @(posedge clk) begin
        if (rst) begin
            assert (32'(occ) == 32'($countones(vld)));
            assert (32'(occ) <= DEPTH);
        end
    end
`endif

endmodule
